dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester (cpu/dbg) round-robin arbiter in front of a single data memory port.
// Each accepted access takes one memory cycle, then one response cycle.
module dmem_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cpu_req_valid_i,
  output logic             cpu_req_ready_o,
  input  logic             cpu_we_i,
  input  logic [2:0]       cpu_width_src_i,
  input  logic [WIDTH-1:0] cpu_addr_i,
  input  logic [WIDTH-1:0] cpu_wdata_i,
  output logic             cpu_rsp_valid_o,
  output logic             cpu_rsp_err_o,
  input  logic             dbg_req_valid_i,
  output logic             dbg_req_ready_o,
  input  logic             dbg_we_i,
  input  logic [2:0]       dbg_width_src_i,
  input  logic [WIDTH-1:0] dbg_addr_i,
  input  logic [WIDTH-1:0] dbg_wdata_i,
  output logic             dbg_rsp_valid_o,
  output logic             dbg_rsp_err_o,
  output logic [WIDTH-1:0] rsp_rdata_o,
  output logic             mem_we_o,
  output logic [2:0]       mem_width_src_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wd_o,
  input  logic [WIDTH-1:0] mem_rd_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_q;
  logic             we_q, err_q, id_q;
  logic [2:0]       width_q;
  logic [WIDTH-1:0] addr_q, wd_q, rdata_q;

  logic             can_acc, gnt_cpu, gnt_dbg, accept;
  logic             s_we, s_err;
  logic [2:0]       s_width;
  logic [WIDTH-1:0] s_addr, s_wd;

  // last_q = 1 means dbg was granted last, so cpu wins the next tie
  assign can_acc = (state_q != ACCESS) & ~reset_i;
  assign gnt_cpu = can_acc & cpu_req_valid_i
                 & (~dbg_req_valid_i | last_q);
  assign gnt_dbg = can_acc & dbg_req_valid_i
                 & (~cpu_req_valid_i | ~last_q);
  assign accept  = gnt_cpu | gnt_dbg;

  assign s_we    = gnt_dbg ? dbg_we_i        : cpu_we_i;
  assign s_width = gnt_dbg ? dbg_width_src_i : cpu_width_src_i;
  assign s_addr  = gnt_dbg ? dbg_addr_i      : cpu_addr_i;
  assign s_wd    = gnt_dbg ? dbg_wdata_i     : cpu_wdata_i;

  always_comb begin
    s_err = 1'b0;
    unique case (s_width[1:0])
      2'b11:   s_err = 1'b1;
      2'b10:   s_err = s_addr[0];
      2'b00:   s_err = |s_addr[1:0];
      default: s_err = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? ACCESS : IDLE;
      ACCESS:  state_d = RESP;
      RESP:    state_d = accept ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      id_q    <= 1'b0;
      width_q <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ACCESS && !we_q) begin
        rdata_q <= err_q ? '0 : mem_rd_i;
      end
      if (accept) begin
        last_q  <= gnt_dbg;
        id_q    <= gnt_dbg;
        we_q    <= s_we;
        err_q   <= s_err;
        width_q <= s_width;
        addr_q  <= s_addr;
        wd_q    <= s_wd;
      end
    end
  end

  assign cpu_req_ready_o = gnt_cpu;
  assign dbg_req_ready_o = gnt_dbg;

  assign cpu_rsp_valid_o = (state_q == RESP) & ~id_q & ~reset_i;
  assign dbg_rsp_valid_o = (state_q == RESP) &  id_q & ~reset_i;
  assign cpu_rsp_err_o   = cpu_rsp_valid_o & err_q;
  assign dbg_rsp_err_o   = dbg_rsp_valid_o & err_q;
  assign rsp_rdata_o     = rdata_q;

  assign mem_we_o        = (state_q == ACCESS) & we_q
                         & ~err_q & ~reset_i;
  assign mem_width_src_o = width_q;
  assign mem_addr_o      = addr_q;
  assign mem_wd_o        = wd_q;

endmodule
